// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers two 4-digit decimal values from a multiplexed
// 7-segment display bus (seg_data/seg_com). Each scan index must be stable for
// MIN_HOLD cycles before its digit is captured. A complete 0..7 scan is
// converted to binary in four cycles.
// Optional build macro SEG_DECODE_STRICT_EN: reject a blank digit that sits
// below a non-blank digit of the same half instead of reading it as zero.
module seg_scan_decoder #(
    parameter int MIN_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_data,
    input  logic [7:0]  seg_com,
    output logic [13:0] left_val,
    output logic [13:0] right_val,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] HOLD  = 4'(MIN_HOLD);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {HUNT, COLLECT, CONVERT} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  expected_reg, expected_next;
    logic [3:0]  hold_cnt_reg, run_len;
    logic [2:0]  last_idx_reg, idx;
    logic        idx_valid, same_idx, capture;
    logic [3:0]  dec_digit;
    logic        dec_blank, dec_illegal, dec_bad;
    logic [3:0]  digit_reg [8];
    logic        strict_err;
    logic        store_en, conv_start, err_pulse;
    logic [1:0]  k_reg;
    logic [13:0] acc_l_reg, acc_r_reg, acc_l_next, acc_r_next;
    logic [2:0]  l_sel, r_sel;
    logic [3:0]  d_l, d_r;
    logic        frame_valid_next, frame_err_next;
    logic [7:0]  err_cnt_next;
    logic        unused_dp;

    // The decimal point carries no digit information.
    assign unused_dp = seg_data[7];

    // Map a single active-low digit enable to its index; anything else is idle.
    always_comb begin
        idx_valid = 1'b1;
        idx       = 3'd0;
        case (seg_com)
            8'hFE: idx = 3'd0;
            8'hFD: idx = 3'd1;
            8'hFB: idx = 3'd2;
            8'hF7: idx = 3'd3;
            8'hEF: idx = 3'd4;
            8'hDF: idx = 3'd5;
            8'hBF: idx = 3'd6;
            8'h7F: idx = 3'd7;
            default: idx_valid = 1'b0;
        endcase
    end

    // Segment pattern to digit; blank and illegal are flagged separately.
    always_comb begin
        dec_digit   = BLANK;
        dec_blank   = 1'b0;
        dec_illegal = 1'b0;
        case (seg_data[6:0])
            7'h3F: dec_digit = 4'd0;
            7'h06: dec_digit = 4'd1;
            7'h5B: dec_digit = 4'd2;
            7'h4F: dec_digit = 4'd3;
            7'h66: dec_digit = 4'd4;
            7'h6D: dec_digit = 4'd5;
            7'h7D: dec_digit = 4'd6;
            7'h07: dec_digit = 4'd7;
            7'h7F: dec_digit = 4'd8;
            7'h6F: dec_digit = 4'd9;
            7'h00: dec_blank = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
        // The ones digit of either half may never be blank.
        dec_bad = dec_illegal || (dec_blank && (idx == 3'd0 || idx == 3'd4));
    end

    // Stability tracking: capture fires once, on the cycle the run reaches MIN_HOLD.
    always_comb begin
        same_idx = idx_valid && (hold_cnt_reg != 4'd0) && (idx == last_idx_reg);
        if (!idx_valid)
            run_len = 4'd0;
        else if (!same_idx)
            run_len = 4'd1;
        else if (hold_cnt_reg >= HOLD)
            run_len = HOLD;
        else
            run_len = hold_cnt_reg + 4'd1;
        capture = idx_valid && (run_len == HOLD) && !(same_idx && hold_cnt_reg == HOLD);
    end

`ifdef SEG_DECODE_STRICT_EN
    logic [7:0] buf_blank;
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_blank
            assign buf_blank[gi] = (digit_reg[gi] == BLANK);
        end
    endgenerate
    // Position 7 is being captured right now, so use the live decode for it.
    assign buf_blank[7] = dec_blank;

    // A blank is only legal as a leading blank within its half.
    assign strict_err =
        (buf_blank[6] && !buf_blank[7]) ||
        (buf_blank[5] && !(buf_blank[6] && buf_blank[7])) ||
        (buf_blank[4] && !(buf_blank[5] && buf_blank[6] && buf_blank[7])) ||
        (buf_blank[2] && !buf_blank[3]) ||
        (buf_blank[1] && !(buf_blank[2] && buf_blank[3])) ||
        (buf_blank[0] && !(buf_blank[1] && buf_blank[2] && buf_blank[3]));
`else
    assign strict_err = 1'b0;
`endif

    // FSM state and expected-index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= HUNT;
            expected_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
        end
    end

    // Next-state logic: frame sequencing and error detection on each capture.
    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        store_en      = 1'b0;
        conv_start    = 1'b0;
        err_pulse     = 1'b0;
        case (state_reg)
            HUNT: begin
                if (capture && idx == 3'd0) begin
                    if (dec_bad) begin
                        err_pulse = 1'b1;
                    end else begin
                        store_en      = 1'b1;
                        expected_next = 3'd1;
                        state_next    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (capture) begin
                    if (dec_bad) begin
                        err_pulse     = 1'b1;
                        expected_next = 3'd0;
                        state_next    = HUNT;
                    end else if (idx == expected_reg) begin
                        if (idx == 3'd7) begin
                            if (strict_err) begin
                                err_pulse  = 1'b1;
                                state_next = HUNT;
                            end else begin
                                store_en   = 1'b1;
                                conv_start = 1'b1;
                                state_next = CONVERT;
                            end
                            expected_next = 3'd0;
                        end else begin
                            store_en      = 1'b1;
                            expected_next = expected_reg + 3'd1;
                        end
                    end else if (idx == 3'd0) begin
                        // Out-of-order restart: drop the old frame, begin a new one.
                        err_pulse     = 1'b1;
                        store_en      = 1'b1;
                        expected_next = 3'd1;
                    end else begin
                        err_pulse     = 1'b1;
                        expected_next = 3'd0;
                        state_next    = HUNT;
                    end
                end
            end
            CONVERT: begin
                if (k_reg == 2'd3)
                    state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

    // Output logic: result pulse at the last conversion step, error pulse and counter.
    always_comb begin
        frame_valid_next = (state_reg == CONVERT) && (k_reg == 2'd3);
        frame_err_next   = err_pulse;
        err_cnt_next     = (err_pulse && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    // Conversion step: left digits 7..4 and right digits 3..0, MSB first, blank as 0.
    always_comb begin
        l_sel      = {1'b1, ~k_reg};
        r_sel      = {1'b0, ~k_reg};
        d_l        = (digit_reg[l_sel] == BLANK) ? 4'd0 : digit_reg[l_sel];
        d_r        = (digit_reg[r_sel] == BLANK) ? 4'd0 : digit_reg[r_sel];
        acc_l_next = (acc_l_reg << 3) + (acc_l_reg << 1) + {10'd0, d_l};
        acc_r_next = (acc_r_reg << 3) + (acc_r_reg << 1) + {10'd0, d_r};
    end

    // Datapath registers: hold tracker, digit buffer, accumulators and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= 4'd0;
            last_idx_reg <= 3'd0;
            for (int i = 0; i < 8; i++)
                digit_reg[i] <= BLANK;
            k_reg        <= 2'd0;
            acc_l_reg    <= 14'd0;
            acc_r_reg    <= 14'd0;
            left_val     <= 14'd0;
            right_val    <= 14'd0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            hold_cnt_reg <= run_len;
            last_idx_reg <= idx;
            if (store_en)
                digit_reg[idx] <= dec_digit;
            if (conv_start) begin
                k_reg     <= 2'd0;
                acc_l_reg <= 14'd0;
                acc_r_reg <= 14'd0;
            end else if (state_reg == CONVERT) begin
                k_reg     <= k_reg + 2'd1;
                acc_l_reg <= acc_l_next;
                acc_r_reg <= acc_r_next;
                if (k_reg == 2'd3) begin
                    left_val  <= acc_l_next;
                    right_val <= acc_r_next;
                end
            end
            frame_valid <= frame_valid_next;
            frame_err   <= frame_err_next;
            err_cnt     <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: table of scan frames plus hand-written
// sequences; expected pulses are queued as stimulus is driven and matched
// by a monitor when frame_valid / frame_err appear.
module tb_seg_scan_decoder;

    localparam int MIN_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_data = 8'h00;
    logic [7:0]  seg_com  = 8'hFF;
    logic [13:0] left_val, right_val;
    logic        frame_valid, frame_err;
    logic [7:0]  err_cnt;

    seg_scan_decoder #(.MIN_HOLD(MIN_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .seg_com    (seg_com),
        .left_val   (left_val),
        .right_val  (right_val),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [13:0] l;
        logic [13:0] r;
        logic [7:0]  ec;
    } evt_t;

    typedef struct {
        logic [63:0] pats;
        int          err_idx;
        logic [13:0] l;
        logic [13:0] r;
    } vec_t;

    evt_t sb[$];
    evt_t mon_e;
    vec_t vecs[11];

    int checks = 0;
    int errors = 0;
    logic [13:0] m_l = 14'd0;
    logic [13:0] m_r = 14'd0;
    logic [7:0]  m_ec = 8'd0;

    function automatic void chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            10: return 8'h00;
            default: return 8'h49;
        endcase
    endfunction

    // Digits listed from index 7 down to index 0 (10 = blank, 11 = illegal).
    function automatic logic [63:0] mk(input int d7, input int d6, input int d5, input int d4,
                                       input int d3, input int d2, input int d1, input int d0);
        return {seg(d7), seg(d6), seg(d5), seg(d4), seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic step(input logic [7:0] com, input logic [7:0] data);
        seg_com  = com;
        seg_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int idx, input logic [7:0] data, input int n);
        logic [7:0] one_hot;
        one_hot = 8'h01 << idx;
        for (int i = 0; i < n; i++)
            step(~one_hot, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(8'hFF, 8'h00);
    endtask

    task automatic expect_err(input int at);
        m_ec = (m_ec == 8'd255) ? m_ec : m_ec + 8'd1;
        sb.push_back('{1'b1, at, m_l, m_r, m_ec});
    endtask

    task automatic expect_ok(input int at, input logic [13:0] l, input logic [13:0] r);
        m_l = l;
        m_r = r;
        sb.push_back('{1'b0, at, l, r, m_ec});
    endtask

    // Scan 0..7, four cycles per index; capture lands on the MIN_HOLD-th edge.
    task automatic run_frame(input logic [63:0] pats, input int err_idx,
                             input logic [13:0] l, input logic [13:0] r, input int gap);
        for (int i = 0; i < 8; i++) begin
            if (i == err_idx)
                expect_err(cyc + MIN_HOLD);
            if (i == 7 && err_idx < 0)
                expect_ok(cyc + MIN_HOLD + 4, l, r);
            hold(i, pats[i*8 +: 8], 4);
        end
        idle(gap);
    endtask

    // Match every output pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            chk("pulse_exclusive", int'(frame_valid & frame_err), 0);
            chk("pulse_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                $display("event cyc=%0d valid=%0b err=%0b left=%0d right=%0d err_cnt=%0d",
                         cyc, frame_valid, frame_err, left_val, right_val, err_cnt);
                chk("pulse_is_err", int'(frame_err), int'(mon_e.is_err));
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("left_val", int'(left_val), int'(mon_e.l));
                chk("right_val", int'(right_val), int'(mon_e.r));
                chk("err_cnt", int'(err_cnt), int'(mon_e.ec));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [63:0] p;

    initial begin
        vecs[0]  = '{mk(3, 0, 0, 0, 10, 1, 2, 0), -1, 14'd3000, 14'd120};
        vecs[1]  = '{mk(3, 0, 0, 0, 10, 11, 2, 0), 2, 14'd0, 14'd0};
        vecs[2]  = '{mk(3, 0, 0, 0, 10, 1, 2, 0), -1, 14'd3000, 14'd120};
        vecs[3]  = '{mk(1, 2, 3, 4, 5, 6, 7, 8), -1, 14'd1234, 14'd5678};
        vecs[4]  = '{mk(4, 3, 2, 1, 9, 8, 7, 6), -1, 14'd4321, 14'd9876};
`ifdef SEG_DECODE_STRICT_EN
        vecs[5]  = '{mk(5, 10, 0, 0, 0, 0, 0, 7), 7, 14'd0, 14'd0};
`else
        vecs[5]  = '{mk(5, 10, 0, 0, 0, 0, 0, 7), -1, 14'd5000, 14'd7};
`endif
        vecs[6]  = '{mk(1, 2, 3, 10, 1, 1, 1, 1), 4, 14'd0, 14'd0};
        vecs[7]  = '{mk(1, 1, 1, 1, 2, 2, 2, 10), 0, 14'd0, 14'd0};
        vecs[8]  = '{mk(10, 10, 4, 2, 10, 10, 10, 5), -1, 14'd42, 14'd5};
        vecs[9]  = '{mk(8, 7, 6, 5, 4, 3, 2, 1) | 64'h8080_8080_8080_8080, -1, 14'd8765, 14'd4321};
        vecs[10] = '{mk(11, 0, 0, 0, 1, 1, 1, 1), 7, 14'd0, 14'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_left_val", int'(left_val), 0);
        chk("reset_right_val", int'(right_val), 0);
        chk("reset_frame_valid", int'(frame_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        idle(3);

        // Table-driven frames
        foreach (vecs[v])
            run_frame(vecs[v].pats, vecs[v].err_idx, vecs[v].l, vecs[v].r, 4);

        // Out-of-sequence index 4 after 0,1,2, then a full 9999/9999 frame
        p = mk(9, 9, 9, 9, 9, 9, 9, 9);
        for (int i = 0; i < 3; i++)
            hold(i, p[i*8 +: 8], 4);
        expect_err(cyc + MIN_HOLD);
        hold(4, p[32 +: 8], 4);
        idle(4);
        run_frame(p, -1, 14'd9999, 14'd9999, 4);

        // One-cycle glitch to index 2 while index 1 is settling
        p = mk(2, 0, 2, 4, 7, 3, 6, 0);
        hold(0, p[0 +: 8], 4);
        step(8'hFD, p[8 +: 8]);
        step(8'hFB, seg(8));
        step(8'hFD, p[8 +: 8]);
        step(8'hFD, p[8 +: 8]);
        for (int i = 2; i < 8; i++) begin
            if (i == 7)
                expect_ok(cyc + MIN_HOLD + 4, 14'd2024, 14'd7360);
            hold(i, p[i*8 +: 8], 4);
        end
        idle(4);

        // Index 0 arriving mid-frame restarts the frame after one error pulse
        p = mk(9, 9, 9, 9, 9, 9, 9, 9);
        for (int i = 0; i < 3; i++)
            hold(i, p[i*8 +: 8], 4);
        p = mk(0, 0, 0, 1, 0, 0, 1, 0);
        expect_err(cyc + MIN_HOLD);
        hold(0, p[0 +: 8], 4);
        for (int i = 1; i < 8; i++) begin
            if (i == 7)
                expect_ok(cyc + MIN_HOLD + 4, 14'd1, 14'd10);
            hold(i, p[i*8 +: 8], 4);
        end
        idle(4);

        // Back-to-back frames: index 0 settles during conversion, so frame B is lost
        run_frame(mk(6, 5, 4, 3, 2, 1, 0, 9), -1, 14'd6543, 14'd2109, 0);
        p = mk(1, 1, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 8; i++)
            hold(i, p[i*8 +: 8], 4);
        idle(4);
        run_frame(mk(7, 7, 7, 7, 8, 8, 8, 8), -1, 14'd7777, 14'd8888, 4);

        // Reset during conversion step k=1
        p = mk(3, 3, 3, 3, 3, 3, 3, 3);
        for (int i = 0; i < 7; i++)
            hold(i, p[i*8 +: 8], 4);
        hold(7, p[56 +: 8], 3);
        rst = 1'b1;
        seg_com = 8'hFF;
        #1;
        chk("midconv_rst_left_val", int'(left_val), 0);
        chk("midconv_rst_right_val", int'(right_val), 0);
        chk("midconv_rst_err_cnt", int'(err_cnt), 0);
        chk("midconv_rst_frame_valid", int'(frame_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_l = 14'd0;
        m_r = 14'd0;
        m_ec = 8'd0;
        idle(8);
        chk("post_rst_left_val", int'(left_val), 0);
        chk("post_rst_right_val", int'(right_val), 0);

        // 256 bad frames: illegal pattern on index 0, counter saturates
        for (int n = 0; n < 256; n++) begin
            expect_err(cyc + MIN_HOLD);
            hold(0, 8'h49, 2);
            idle(1);
        end
        idle(2);
        chk("err_cnt_saturated", int'(err_cnt), 255);

        idle(8);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter MIN_HOLD, default 2: consecutive cycles a seg_com code must be stable before its digit is captured (range 1..15).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seg_data  input  8  segment pattern, active-high, bit0=a..bit6=g, bit7=dp.
REQ-005 seg_com  input  8  digit enables, active-low; bit n low selects digit n (0..3 right value, 4..7 left value, bit0/bit4 = ones).
REQ-006 left_val  output  14  last good decoded left value (0..9999).
REQ-007 right_val  output  14  last good decoded right value (0..9999).
REQ-008 frame_valid  output  1  one-cycle pulse when left_val/right_val update.
REQ-009 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-010 err_cnt  output  8  count of discarded frames, saturates at 255.

Function
REQ-011 seg_com with exactly one low bit SHALL be a valid index; 0xFF or more than one low bit SHALL be idle: it does not capture, advance, or break a sequence, and it restarts the hold counter.
REQ-012 A valid index SHALL be captured once, when it has been stable for MIN_HOLD consecutive cycles; later cycles on the same index SHALL NOT recapture.
REQ-013 Segment decode, bit7 ignored: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x00=blank; any other pattern SHALL be illegal.
REQ-014 FSM states HUNT, COLLECT, CONVERT.
REQ-015 HUNT: capture of index 0 SHALL store the digit, set expected=1 and go to COLLECT; captures of other indices SHALL be ignored without error.
REQ-016 COLLECT: capture of index==expected SHALL store the digit and increment expected. Capture of index 7 SHALL go to CONVERT. Any other index SHALL pulse frame_err and go to HUNT. If that index is 0, it SHALL be taken as the start of a new frame (store the digit, expected=1, stay in COLLECT).
REQ-017 An illegal pattern captured at any index in COLLECT, or at index 0 in HUNT, SHALL pulse frame_err and return to HUNT.
REQ-018 A blank at index 0 or 4 SHALL be an error, handled as in REQ-017.
REQ-019 CONVERT SHALL take exactly 4 cycles, k=0..3. Processing is MSB first (left digits 7..4, right digits 3..0 in parallel): acc = acc*10 + d, with acc*10 formed as (acc<<3)+(acc<<1) and blank taken as 0.
REQ-020 At the clock edge ending k=3, left_val and right_val SHALL load and frame_valid SHALL pulse for one cycle, 4 cycles after the index-7 capture; the FSM SHALL then go to HUNT.
REQ-021 Captures SHALL be ignored during CONVERT; the hold counter SHALL keep running, so an index-0 code already stable for MIN_HOLD at HUNT entry is not captured until it changes.
REQ-022 frame_err SHALL increment err_cnt in the same edge; at 255 err_cnt SHALL hold. frame_valid and frame_err SHALL never both be high in one cycle.
REQ-023 left_val/right_val SHALL hold between frames; a discarded frame SHALL NOT alter them.

Reset
REQ-024 While rst is high: FSM=HUNT, hold counter=0, expected=0, digit buffer=blank, accumulators=0, left_val=0, right_val=0, frame_valid=0, frame_err=0, err_cnt=0.
REQ-025 rst asserted mid-COLLECT or mid-CONVERT SHALL abort the frame with no frame_valid or frame_err pulse.

Configuration
REQ-026 Macro SEG_DECODE_STRICT_EN. When defined, a blank at a digit position lower than any non-blank digit of the same half (e.g. left digits 5,blank,0,0) SHALL be an error per REQ-017. When undefined, that blank SHALL decode as 0 without error.

Verification
REQ-027 MIN_HOLD=2. Scan 0..7, 4 cycles each: right=blank,1,2,0 (idx3..0) and left=3,0,0,0 (idx7..4) -> frame_valid 4 cycles after idx7 capture, left_val=3000, right_val=120, err_cnt=0.
REQ-028 Same frame, but idx2 seg_data=0x49 -> one frame_err pulse, err_cnt=1, outputs keep their previous values; the next clean frame decodes normally.
REQ-029 Sequence 0,1,2,4 -> frame_err at the idx4 capture; a following full 0..7 frame with left 9999, right 9999 -> left_val=9999, right_val=9999.
REQ-030 One-cycle glitch seg_com=0xFB during idx1 hold with MIN_HOLD=2 -> no capture, no error, frame completes correctly.
REQ-031 Left digits 5,blank,0,0 -> with SEG_DECODE_STRICT_EN: frame_err; without it: left_val=5000.
REQ-032 rst pulsed during CONVERT k=1 -> all outputs 0, no pulses; 256 consecutive bad frames -> err_cnt holds at 255.
